// File: rtl/edge_point_writer_pkg.sv
// Shared definitions for the edge point writer: FSM encoding, default
// image geometry, buffer depth and coordinate width.
package edge_point_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_IMG_W     = 640;
    localparam int DEF_IMG_H     = 360;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_POINT_MSB = 15;
    localparam int POINT_W       = DEF_POINT_MSB + 1;

endpackage

// File: rtl/point_fifo.sv
// First-word-fall-through point buffer with synchronous flush.
// Head reads as zero while empty.
module point_fifo
    import edge_point_writer_pkg::*;
#(
    parameter int WIDTH = 2 * POINT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [7:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 8'(DEPTH));
    assign empty   = (count == 8'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // A flush can coincide with the restarting pixel's own push.
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? 8'd1 : 8'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + 8'(do_push) - 8'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (flush && push)
            mem[0] <= din;
        else if (!flush && do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/edge_point_writer.sv
// Scans a Canny edge raster, buffers {col,row} of edge pixels and hands
// them to a consumer; tracks frame boundaries via sof.
module edge_point_writer
    import edge_point_writer_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int msb_point = DEF_POINT_MSB
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic               pix_edge,
    input  logic               sof,
    output logic               pix_ready,
    output logic [msb_point:0] x,
    output logic [msb_point:0] y,
    input  logic               inc_address,
    output logic               end_point,
    output logic [7:0]         cnt_xy,
    output logic               frame_err
);

    localparam int PW = msb_point + 1;
    localparam logic [msb_point:0] COL_LAST = PW'(IMG_W - 1);
    localparam logic [msb_point:0] ROW_LAST = PW'(IMG_H - 1);

    state_t            state, state_nx;
    logic [msb_point:0] col, row, col_nx, row_nx, eff_col, eff_row;
    logic              accept, process, flush, err_nx, full, empty;
    logic [2*PW-1:0]   head;

    assign pix_ready = !full && (state != ST_DRAIN);
    assign accept    = pix_valid && pix_ready;
    assign end_point = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        process  = 1'b0;
        flush    = 1'b0;
        err_nx   = 1'b0;
        // An sof pixel is always treated as (0,0), whatever the counters say.
        eff_col  = sof ? '0 : col;
        eff_row  = sof ? '0 : row;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept && sof) process = 1'b1;
            end
            ST_COLLECT: begin
                if (accept) begin
                    process = 1'b1;
                    if (sof && (col != '0 || row != '0)) begin
                        flush  = 1'b1;
                        err_nx = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (empty) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (process) begin
            state_nx = ST_COLLECT;
            if (eff_col == COL_LAST) begin
                col_nx = '0;
                if (eff_row == ROW_LAST) begin
                    row_nx   = '0;
                    state_nx = ST_DRAIN;
                end else begin
                    row_nx = eff_row + PW'(1);
                end
            end else begin
                col_nx = eff_col + PW'(1);
                row_nx = eff_row;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            row       <= row_nx;
            frame_err <= err_nx;
        end
    end

    point_fifo #(
        .WIDTH(2 * PW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .push (process && pix_edge),
        .din  ({eff_col, eff_row}),
        .pop  (inc_address),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(cnt_xy)
    );

    assign x = head[2*PW-1:PW];
    assign y = head[PW-1:0];

endmodule

// File: tb/tb_edge_point_writer.sv
// Scoreboard bench for edge_point_writer (8x4 frame, 4-entry buffer).
module tb_edge_point_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid, pix_edge, sof, inc_address;
    logic        pix_ready, end_point, frame_err;
    logic [15:0] x, y;
    logic [7:0]  cnt_xy;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_q[$];

    edge_point_writer #(
        .IMG_W(8),
        .IMG_H(4),
        .DEPTH(4),
        .msb_point(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_edge   (pix_edge),
        .sof        (sof),
        .pix_ready  (pix_ready),
        .x          (x),
        .y          (y),
        .inc_address(inc_address),
        .end_point  (end_point),
        .cnt_xy     (cnt_xy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic s, input logic e);
        int unsigned n;
        n = 0;
        pix_valid = 1'b1;
        sof       = s;
        pix_edge  = e;
        while (!pix_ready && n < 50) begin
            cycle();
            n++;
        end
        if (!pix_ready) begin
            n_total++;
            $display("FAIL ready_timeout: pix_ready stuck at 0, expected 1");
        end
        cycle();
        pix_valid = 1'b0;
        sof       = 1'b0;
        pix_edge  = 1'b0;
    endtask

    task automatic wait_end();
        int unsigned n;
        n = 0;
        while (!end_point && n < 50) begin
            cycle();
            n++;
        end
        check("end_point_reached", end_point, 1);
    endtask

    task automatic push_exp(input int c, input int r);
        exp_q.push_back({16'(c), 16'(r)});
    endtask

    // Monitor: every effective pop must present the next expected point.
    always @(negedge clk) begin
        if (reset && inc_address && cnt_xy != 8'd0) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL pop_order: got (%0d,%0d), expected no point", x, y);
            end else begin
                check("pop_order", {x, y}, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset       = 1'b0;
        pix_valid   = 1'b0;
        pix_edge    = 1'b0;
        sof         = 1'b0;
        inc_address = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        check("rst_cnt", cnt_xy, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_end", end_point, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ready", pix_ready, 1);

        // Single edge at (3,2), no pops during the frame
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (c == 3 && r == 2) push_exp(3, 2);
                send_pix(r == 0 && c == 0, c == 3 && r == 2);
                if (c == 3 && r == 2) begin
                    check("single_cnt", cnt_xy, 1);
                    check("single_x", x, 3);
                    check("single_y", y, 2);
                end
            end
        end
        check("drain_ready", pix_ready, 0);
        check("drain_end", end_point, 0);
        cycle();
        check("drain_hold_end", end_point, 0);
        inc_address = 1'b1;
        cycle();
        inc_address = 1'b0;
        check("drain_cnt", cnt_xy, 0);
        check("drain_end_lag", end_point, 0);
        cycle();
        check("done_end", end_point, 1);
        check("done_ready", pix_ready, 1);

        // Backpressure: row 0 all edges
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r == 0) push_exp(c, 0);
                send_pix(r == 0 && c == 0, r == 0);
                if (r == 0 && c == 0) check("restart_end_drop", end_point, 0);
                if (r == 0 && c == 3) begin
                    check("bp_cnt_full", cnt_xy, 4);
                    check("bp_ready_low", pix_ready, 0);
                    inc_address = 1'b1;
                    cycle();
                    check("bp_ready_back", pix_ready, 1);
                    check("bp_cnt_after_pop", cnt_xy, 3);
                end
            end
        end
        wait_end();
        inc_address = 1'b0;
        check("bp_all_popped", exp_q.size(), 0);

        // Empty pop is ignored
        inc_address = 1'b1;
        cycle();
        inc_address = 1'b0;
        check("empty_pop_cnt", cnt_xy, 0);
        check("empty_pop_x", x, 0);
        check("empty_pop_y", y, 0);

        // Concurrent push/pop at cnt_xy=2
        push_exp(0, 0);
        send_pix(1'b1, 1'b1);
        push_exp(1, 0);
        send_pix(1'b0, 1'b1);
        check("pp_cnt_before", cnt_xy, 2);
        inc_address = 1'b1;
        push_exp(2, 0);
        send_pix(1'b0, 1'b1);
        inc_address = 1'b0;
        check("pp_cnt_after", cnt_xy, 2);
        check("pp_head_x", x, 1);
        check("pp_head_y", y, 0);

        // Mid-frame sof at (5,1) with two points buffered
        for (int i = 0; i < 10; i++) send_pix(1'b0, 1'b0);
        send_pix(1'b1, 1'b0);
        exp_q.delete();
        check("mid_sof_ferr", frame_err, 1);
        check("mid_sof_cnt", cnt_xy, 0);
        cycle();
        check("mid_sof_ferr_pulse", frame_err, 0);
        push_exp(1, 0);
        send_pix(1'b0, 1'b1);
        check("mid_sof_cnt1", cnt_xy, 1);
        check("mid_sof_x", x, 1);
        check("mid_sof_y", y, 0);

        // Reset while presenting (6,3) with three points buffered
        push_exp(2, 0);
        send_pix(1'b0, 1'b1);
        push_exp(3, 0);
        send_pix(1'b0, 1'b1);
        check("pre_rst_cnt", cnt_xy, 3);
        for (int i = 0; i < 26; i++) send_pix(1'b0, 1'b0);
        pix_valid = 1'b1;
        pix_edge  = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("mrst_cnt", cnt_xy, 0);
        check("mrst_x", x, 0);
        check("mrst_y", y, 0);
        check("mrst_end", end_point, 0);
        check("mrst_ferr", frame_err, 0);
        check("mrst_ready", pix_ready, 1);
        pix_valid = 1'b0;
        pix_edge  = 1'b0;
        exp_q.delete();
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) send_pix(1'b0, 1'b1);
        check("idle_discard_cnt", cnt_xy, 0);
        check("idle_ready", pix_ready, 1);
        check("idle_end", end_point, 0);
        send_pix(1'b1, 1'b0);
        push_exp(1, 0);
        send_pix(1'b0, 1'b1);
        check("post_rst_cnt", cnt_xy, 1);
        check("post_rst_x", x, 1);
        check("post_rst_y", y, 0);
        inc_address = 1'b1;
        cycle();
        inc_address = 1'b0;
        check("post_rst_pop_cnt", cnt_xy, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/edge_point_writer.md
EDGE_POINT_WRITER -- requirements
Module: edge_point_writer

Interface
REQ-001 Parameter IMG_W, default 640: pixels per raster row.
REQ-002 Parameter IMG_H, default 360: rows per frame.
REQ-003 Parameter DEPTH, default 64: point buffer entries, power of two, maximum 128.
REQ-004 Parameter msb_point, default 15: MSB of the x and y coordinates.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-007 pix_valid  in  1  Canny pixel present this cycle.
REQ-008 pix_edge  in  1  pixel is an edge (1) or background (0).
REQ-009 sof  in  1  start of frame; qualified by pix_valid, marks pixel (0,0).
REQ-010 pix_ready  out  1  pixel accepted when pix_valid&pix_ready.
REQ-011 x  out  msb_point+1  column of the buffer head point.
REQ-012 y  out  msb_point+1  row of the buffer head point.
REQ-013 inc_address  in  1  consumer pops the head point.
REQ-014 end_point  out  1  frame fully scanned and buffer empty.
REQ-015 cnt_xy  out  8  buffer occupancy, 0..DEPTH.
REQ-016 frame_err  out  1  one-cycle pulse on sof received mid-frame.

Function
REQ-017 FSM states: IDLE, COLLECT, DRAIN, DONE.
REQ-018 IDLE: pixels without sof are discarded (pix_ready=1); an accepted sof pixel enters COLLECT, and that pixel is processed as (0,0).
REQ-019 COLLECT: raster counters col 0..IMG_W-1 and row 0..IMG_H-1 advance per accepted pixel; col wraps to 0 and increments row.
REQ-020 An accepted pixel with pix_edge=1 pushes {col,row} into the buffer.
REQ-021 Accepting pixel (IMG_W-1, IMG_H-1) moves the FSM to DRAIN.
REQ-022 DRAIN: pix_ready=0; moves to DONE in the cycle after the buffer becomes empty.
REQ-023 DONE: end_point=1 and pix_ready=1; an accepted sof pixel returns the FSM to COLLECT as (0,0), and end_point drops in the next cycle.
REQ-024 pix_ready=0 whenever the buffer is full or the FSM is in DRAIN (backpressure); the counters hold.
REQ-025 Buffer is first-word fall-through: a point pushed into an empty buffer appears on x/y in the next cycle.
REQ-026 x and y are 0 whenever cnt_xy=0.
REQ-027 inc_address with cnt_xy>0 pops the head; inc_address with cnt_xy=0 is ignored.
REQ-028 Simultaneous push and pop while not full: cnt_xy unchanged, order preserved.
REQ-029 A pop while full raises pix_ready in the next cycle; there is no push in the full cycle.
REQ-030 sof accepted in COLLECT (not at (0,0) of the current frame): flush the buffer, restart at (0,0) with that pixel, and pulse frame_err.
REQ-031 Coordinates are zero-extended to msb_point+1 bits.

Reset
REQ-032 Asynchronous reset (reset=0) forces: state IDLE, counters 0, buffer pointers 0, cnt_xy=0, x=0, y=0, end_point=0, frame_err=0, pix_ready=1.
REQ-033 Reset mid-frame discards all buffered points.
REQ-034 After reset deasserts, the block waits for the next sof.

Structure
REQ-035 A shared package holds the FSM state encoding, the default IMG_W/IMG_H/DEPTH values, and the point width.
REQ-036 The buffer is one sub-module, point_fifo (push, pop, full, empty, count, FWFT head).
REQ-037 The FSM, raster counters and sof checking live in edge_point_writer.

Verification
REQ-038 Test parameters: IMG_W=8, IMG_H=4, DEPTH=4 unless noted.
REQ-039 Single edge: frame with only (3,2) set, no pops -> x=3, y=2, cnt_xy=1 one cycle after acceptance; end_point stays 0. Then pop -> end_point=1 one cycle after the buffer empties.
REQ-040 Backpressure: row 0 all edges, no pops -> pix_ready=0 after the 4th edge and cnt_xy=4. One pop -> pix_ready=1 next cycle; pixel (4,0) is accepted with no loss.
REQ-041 Mid-frame sof: sof at (5,1) with 2 points buffered -> frame_err pulse, cnt_xy=0, next accepted pixel counted as (1,0).
REQ-042 Reset at (6,3) with 3 points buffered -> all outputs at reset values; non-sof pixels ignored until sof.
REQ-043 Empty pop plus concurrent push/pop: inc_address with cnt_xy=0 -> no change. Push and pop in the same cycle at cnt_xy=2 -> cnt_xy stays 2, FIFO order intact.
